preg_free_list: RTL
===================

Name: preg_free_list

Overview:
- Owns the physical-register free pool for the 2-wide rename stage.
- Grants up to two physical destination registers per cycle, lowest free index first, all-or-nothing.
- Returns registers to the pool from the retire stage's one-hot free mask.
- Backpressures rename with alloc_ready when too few registers are free, and flags double frees.

Parameters:
- NUM_PREGS, 64, number of physical registers; pool bit width.
- NUM_AREGS, 32, architectural registers; pregs 0..NUM_AREGS-1 start mapped (not free).
- PREG_W, 6, physical register index width, log2(NUM_PREGS).
- CNT_W, 7, free_count width, log2(NUM_PREGS)+1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- alloc_req_1  in  1  rename slot 1 needs a destination preg this cycle.
- alloc_req_2  in  1  rename slot 2 needs a destination preg this cycle.
- alloc_ready  out  1  all asserted requests can be granted this cycle (combinational).
- alloc_preg_1  out  PREG_W  preg granted to slot 1 (combinational, from current pool).
- alloc_preg_2  out  PREG_W  preg granted to slot 2 (combinational, from current pool).
- free_mask  in  NUM_PREGS  one-hot-per-bit mask from retire; bit set = preg released.
- free_count  out  CNT_W  registered count of free pregs.
- double_free_err  out  1  sticky flag: a released preg was already free.

Behaviour:
- State: pool[NUM_PREGS-1:0] (1 = free), free_count, double_free_err. All registered.
- Reset (rst_n low, asynchronous):
  - pool[NUM_AREGS..NUM_PREGS-1]=1, others 0.
  - free_count=NUM_PREGS-NUM_AREGS (32).
  - double_free_err=0.
  - Reset applies immediately even mid-allocation; no grant commits on an edge where rst_n is low.
- Preg 0 is never allocated. free_mask[0] is ignored and does not raise the error.
- Selection (combinational, current pool only):
  - f0 = lowest-index free bit; f1 = second-lowest free bit.
  - If req_1 & req_2: preg_1=f0, preg_2=f1.
  - If only req_1: preg_1=f0. If only req_2: preg_2=f0.
  - A slot without a request drives 0. A slot whose candidate does not exist drives 0.
- Ready rule:
  - need = req_1 + req_2 (0..2).
  - alloc_ready = (free_count >= need); alloc_ready=1 when need=0.
  - Grants are all-or-nothing: when alloc_ready=0 nothing commits and the pool is unchanged by allocation.
- Commit at posedge when alloc_ready & need>0: granted bits are cleared in the pool. Latency 0 (grant visible in the request cycle), state update at the next edge.
- Free: at every posedge, pool |= free_mask & ~1. Freed pregs are grantable from the following cycle; there is no same-cycle bypass.
- Next state: pool_n = (pool & ~grant_mask) | (free_mask & ~1); free_count_n = popcount(pool_n).
- Double free: if any bit in (free_mask & pool & ~1) is set at an edge, double_free_err sets to 1 and holds until reset. The pool bit simply stays 1.
- Free and grant at the same edge: free_mask can only name a preg that is currently allocated, so it never collides with a grant. A collision is itself a double free and is flagged.
- Boundaries:
  - free_count=1 with both requests -> alloc_ready=0, no grant (slot 1 is not granted alone).
  - free_count=0 -> preg outputs 0.
  - free_count max is NUM_PREGS-1 (63).

Test Plan:
- Reset release, no requests -> free_count=32, alloc_ready=1, double_free_err=0; preg_1 reads 0 when not requested.
- req_1=req_2=1 for one cycle after reset -> preg_1=32, preg_2=33 that cycle; next cycle free_count=30, and a fresh dual request yields 34/35.
- Dual requests for 16 cycles -> pregs 32..63 handed out in order, free_count=0; then req_1 alone -> alloc_ready=0, outputs 0, pool unchanged.
- From empty pool, free_mask bits 40 and 5 set for one cycle -> next cycle free_count=2 and a dual request yields 5/40. A free_mask with only bit 0 set -> free_count unchanged.
- After reset, free_mask bit 50 set (50 is already free) -> double_free_err=1 next cycle and stays 1 across 10 idle cycles; free_count remains 32.
- Mid-run with free_count=10 and dual requests active, pulse rst_n low between edges -> outputs immediately return to reset values; after release, free_count=32 and next grants are 32/33.

Source files
------------

// File: rtl/preg_free_list.sv
// Physical-register free pool for a 2-wide rename stage.
// Grants up to two free pregs per cycle (lowest index first, all-or-nothing),
// takes released pregs back from retire, and flags any release of a preg
// that was already free.
module preg_free_list #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32,
    parameter int PREG_W    = 6,
    parameter int CNT_W     = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc_req_1,
    input  logic                 alloc_req_2,
    output logic                 alloc_ready,
    output logic [PREG_W-1:0]    alloc_preg_1,
    output logic [PREG_W-1:0]    alloc_preg_2,
    input  logic [NUM_PREGS-1:0] free_mask,
    output logic [CNT_W-1:0]     free_count,
    output logic                 double_free_err
);

    // Pregs below NUM_AREGS hold the initial architectural mapping, so only
    // the upper part of the pool starts free.
    localparam logic [NUM_PREGS-1:0] RESET_POOL  = {NUM_PREGS{1'b1}} << NUM_AREGS;
    localparam logic [CNT_W-1:0]     RESET_COUNT = CNT_W'(NUM_PREGS - NUM_AREGS);

    logic [NUM_PREGS-1:0] pool_q;
    logic [NUM_PREGS-1:0] pool_d;
    logic [CNT_W-1:0]     freeCount_q;
    logic [CNT_W-1:0]     freeCount_d;
    logic                 doubleFreeErr_q;
    logic                 doubleFreeErr_d;

    logic [PREG_W-1:0]    firstFree;
    logic [PREG_W-1:0]    secondFree;
    logic                 firstValid;
    logic                 secondValid;
    logic [1:0]           need;
    logic [NUM_PREGS-1:0] grantMask;
    logic [NUM_PREGS-1:0] releaseMask;

    // Find the two lowest free pregs; preg 0 is never a candidate.
    always_comb begin
        firstFree   = '0;
        secondFree  = '0;
        firstValid  = 1'b0;
        secondValid = 1'b0;
        for (int i = 1; i < NUM_PREGS; i++) begin
            if (pool_q[i]) begin
                if (!firstValid) begin
                    firstFree  = PREG_W'(i);
                    firstValid = 1'b1;
                end else if (!secondValid) begin
                    secondFree  = PREG_W'(i);
                    secondValid = 1'b1;
                end
            end
        end
    end

    // Route candidates to slots, decide readiness and build the grant mask.
    // A lone slot-2 request takes the lowest free preg; slots without a
    // request or without a candidate show 0. Nothing is granted unless every
    // asserted request can be satisfied.
    always_comb begin
        need         = {1'b0, alloc_req_1} + {1'b0, alloc_req_2};
        alloc_ready  = (freeCount_q >= CNT_W'(need));
        alloc_preg_1 = '0;
        alloc_preg_2 = '0;
        grantMask    = '0;
        if (alloc_req_1) begin
            if (firstValid) begin
                alloc_preg_1 = firstFree;
            end
            if (alloc_req_2 && secondValid) begin
                alloc_preg_2 = secondFree;
            end
        end else if (alloc_req_2 && firstValid) begin
            alloc_preg_2 = firstFree;
        end
        if (alloc_ready) begin
            if ((alloc_req_1 || alloc_req_2) && firstValid) begin
                grantMask[firstFree] = 1'b1;
            end
            if (alloc_req_1 && alloc_req_2 && secondValid) begin
                grantMask[secondFree] = 1'b1;
            end
        end
    end

    // Next pool: drop granted pregs, add released ones (bit 0 ignored), then
    // recount; releasing an already-free preg latches the sticky error.
    always_comb begin
        releaseMask     = free_mask;
        releaseMask[0]  = 1'b0;
        pool_d          = (pool_q & ~grantMask) | releaseMask;
        freeCount_d     = '0;
        for (int i = 0; i < NUM_PREGS; i++) begin
            freeCount_d = freeCount_d + CNT_W'(pool_d[i]);
        end
        doubleFreeErr_d = doubleFreeErr_q | (|(releaseMask & pool_q));
    end

    // Pool, count and error register; reset wins over any pending grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pool_q          <= RESET_POOL;
            freeCount_q     <= RESET_COUNT;
            doubleFreeErr_q <= 1'b0;
        end else begin
            pool_q          <= pool_d;
            freeCount_q     <= freeCount_d;
            doubleFreeErr_q <= doubleFreeErr_d;
        end
    end

    assign free_count      = freeCount_q;
    assign double_free_err = doubleFreeErr_q;

endmodule
